riscv_load_store_unit: RTL and testbench

Memory-access stage directly downstream of the ALU in the multi-cycle RISC-V core. It takes the effective address computed by the ALU (rs1+Iimm or rs1+Simm), the store value (rs2) and funct3, and runs one load or store against a word-wide data memory with a ready handshake. For loads it returns sign- or zero-extended write-back data to the register-file write port. The core's state machine waits in a WAIT_DATA state while busy is high.

---
 rtl/riscv_lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 55 +++++
 rtl/riscv_load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_riscv_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, funct3
// access-width codes, fault codes, and the request classifier used at accept.
package riscv_lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t REQ  = 2'd1;
  localparam lsu_state_t WAIT = 2'd2;
  localparam lsu_state_t RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  // Illegal opcode/width takes precedence over misalignment.
  function automatic logic [1:0] classify_access(input logic       is_load,
                                                 input logic       is_store,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    legal = 1'b0;
    if (is_load && !is_store)
      legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else if (is_store && !is_load)
      legal = f3 inside {F3_B, F3_H, F3_W};
    case (f3)
      F3_H, F3_HU: aligned = ~addr_lo[0];
      F3_W:        aligned = (addr_lo == 2'b00);
      default:     aligned = 1'b1;
    endcase
    if (!legal)
      return FLT_ILLEGAL;
    if (!aligned)
      return FLT_MISALIGN;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   st_funct3/st_addr_lo/st_data : store request -> wdata (lane replicated), wmask
//   ld_funct3/ld_addr_lo/ld_rdata: load request  -> ld_value (extracted, extended)
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (st_funct3)
      F3_B: begin
        wdata = {4{st_data[7:0]}};
        wmask = 4'b0001 << st_addr_lo;
      end
      F3_H: begin
        wdata = {2{st_data[15:0]}};
        wmask = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = st_data;
        wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_value = {24'd0, ld_byte};
      F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_value = {16'd0, ld_half};
      default: ld_value = ld_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_load_store_unit.sv
// Memory-access stage: runs one load or store against a word-wide data
// memory with a ready handshake and returns extended load data.
//   CLK, RESET          : clock, synchronous active-high reset
//   start/isLoad/isStore/funct3/addr/storeData : request from the core
//   busy, done, fault, faultCode, loadData     : status and write-back data
//   mem_addr/mem_rstrb/mem_wdata/mem_wmask     : memory request (registered)
//   mem_rdata/mem_ready                         : memory response
//
// state | meaning
// IDLE  | waiting for an accepted start
// REQ   | one-cycle memory strobe (read strobe or write mask)
// WAIT  | waiting for mem_ready, bounded by TIMEOUT cycles
// RESP  | one-cycle done pulse, fault reported if any
module riscv_load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        fault,
  output logic [1:0]  faultCode,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          op_load, op_load_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    alo_q, alo_d;
  logic          busy_d, done_d, fault_d, rstrb_d;
  logic [1:0]    code_d;
  logic [3:0]    wmask_d;
  logic [31:0]   load_d, addr_d, wdata_d;
  logic          accept, timed_out;
  logic [1:0]    req_code;
  logic [31:0]   al_wdata, al_load;
  logic [3:0]    al_wmask;

  assign accept    = (state == IDLE) && start && (isLoad || isStore);
  assign req_code  = classify_access(isLoad, isStore, funct3, addr[1:0]);
  assign cnt_inc   = cnt + CW'(1);
  assign timed_out = (cnt_inc == CW'(TIMEOUT));

  // Store steering uses the live request; load extraction uses the latched one.
  lsu_align u_align (
    .st_funct3  (funct3),
    .st_addr_lo (addr[1:0]),
    .st_data    (storeData),
    .ld_funct3  (f3_q),
    .ld_addr_lo (alo_q),
    .ld_rdata   (mem_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .ld_value   (al_load)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      op_load   <= 1'b0;
      f3_q      <= 3'd0;
      alo_q     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      faultCode <= FLT_NONE;
      loadData  <= 32'd0;
      mem_addr  <= 32'd0;
      mem_rstrb <= 1'b0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_d;
      op_load   <= op_load_d;
      f3_q      <= f3_d;
      alo_q     <= alo_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      faultCode <= code_d;
      loadData  <= load_d;
      mem_addr  <= addr_d;
      mem_rstrb <= rstrb_d;
      mem_wdata <= wdata_d;
      mem_wmask <= wmask_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (req_code != FLT_NONE) ? RESP : REQ;
      REQ:  state_next = WAIT;
      WAIT: if (mem_ready || timed_out) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Computes the next value of every registered output, so each output
  // changes on the same edge as the state it belongs to.
  always_comb begin
    busy_d    = (state_next != IDLE);
    done_d    = 1'b0;
    rstrb_d   = 1'b0;
    wmask_d   = 4'd0;
    fault_d   = fault;
    code_d    = faultCode;
    cnt_d     = cnt;
    load_d    = loadData;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    op_load_d = op_load;
    f3_d      = f3_q;
    alo_d     = alo_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_load_d = isLoad;
          f3_d      = funct3;
          alo_d     = addr[1:0];
          fault_d   = 1'b0;
          code_d    = FLT_NONE;
          cnt_d     = '0;
          if (req_code != FLT_NONE) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
            code_d  = req_code;
          end else begin
            addr_d = {addr[31:2], 2'b00};
            if (isLoad) begin
              rstrb_d = 1'b1;
            end else begin
              wmask_d = al_wmask;
              wdata_d = al_wdata;
            end
          end
        end
      end
      REQ: cnt_d = '0;
      WAIT: begin
        if (mem_ready) begin
          done_d = 1'b1;
          if (op_load)
            load_d = al_load;
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
            code_d  = FLT_TIMEOUT;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
module tb_riscv_load_store_unit;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RESET, start, isLoad, isStore, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData, mem_rdata;
  logic        busy, done, fault, mem_rstrb;
  logic [1:0]  faultCode;
  logic [31:0] loadData, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int          total = 0;
  int          passed = 0;
  logic [31:0] m_load = 32'd0;

  riscv_load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .isLoad(isLoad), .isStore(isStore),
    .funct3(funct3), .addr(addr), .storeData(storeData), .busy(busy), .done(done),
    .loadData(loadData), .fault(fault), .faultCode(faultCode), .mem_addr(mem_addr),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] m_code(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [31:0] a);
    if (ld && st) return 2'b10;
    if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) return 2'b10;
    if (st && f3 > 3'b010) return 2'b10;
    if ((a % acc_size(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    int     sz, off;
    longint val, span;
    sz  = acc_size(f3);
    off = ((a % 4) / sz) * sz;
    val = longint'(rd) >> (8 * off);
    if (sz < 4) begin
      span = longint'(1) << (8 * sz);
      val  = val % span;
      if (f3[2] == 1'b0 && val >= span / 2) val = val - span;
    end
    return 32'(val);
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz, off;
    sz  = acc_size(f3);
    off = ((a % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz;
    sz = acc_size(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int delay, input bit poke);
    logic [1:0] code;
    int         exp_i, got_i, spurious;
    code = m_code(ld, st, f3, a);
    start = 1'b1; isLoad = ld; isStore = st; funct3 = f3; addr = a; storeData = sd;
    mem_ready = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0; isLoad = 1'b0; isStore = 1'b0;
    addr = $urandom; storeData = $urandom; funct3 = 3'($urandom);
    if (code != 2'b00) begin
      check({tag, "/early_done"}, done, 1);
      check({tag, "/early_fault"}, fault, 1);
      check({tag, "/early_code"}, faultCode, code);
      check({tag, "/early_rstrb"}, mem_rstrb, 0);
      check({tag, "/early_wmask"}, mem_wmask, 0);
      check({tag, "/early_load"}, loadData, m_load);
      @(posedge CLK); #1;
      check({tag, "/early_done_off"}, done, 0);
      check({tag, "/early_idle"}, busy, 0);
    end else begin
      check({tag, "/req_busy"}, busy, 1);
      check({tag, "/req_done"}, done, 0);
      check({tag, "/req_fault"}, fault, 0);
      check({tag, "/req_code"}, faultCode, 0);
      check({tag, "/req_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "/req_rstrb"}, mem_rstrb, ld);
      check({tag, "/req_wmask"}, mem_wmask, st ? m_mask(f3, a) : 4'd0);
      if (st) check({tag, "/req_wdata"}, mem_wdata, m_wdata(f3, sd));
      mem_ready = 1'b1; mem_rdata = $urandom;
      @(posedge CLK); #1;
      check({tag, "/wait_strobe"}, {mem_rstrb, mem_wmask}, 0);
      exp_i    = (delay < TIMEOUT) ? delay : TIMEOUT - 1;
      got_i    = -1;
      spurious = 0;
      for (int i = 0; i < 40 && got_i < 0; i++) begin
        mem_ready = (i == delay);
        mem_rdata = (i == delay) ? rd : $urandom;
        if (poke && i == 1) begin
          start = 1'b1; isLoad = 1'b1; funct3 = 3'b010; addr = 32'h0;
        end
        @(posedge CLK); #1;
        start = 1'b0; isLoad = 1'b0;
        if (mem_rstrb || mem_wmask != 4'd0) spurious++;
        if (done) got_i = i;
      end
      mem_ready = 1'b0;
      check({tag, "/done_cycle"}, got_i, exp_i);
      check({tag, "/no_extra_strobe"}, spurious, 0);
      if (delay < TIMEOUT) begin
        if (ld) m_load = m_extract(f3, a, rd);
        check({tag, "/fault"}, fault, 0);
        check({tag, "/code"}, faultCode, 0);
      end else begin
        check({tag, "/to_fault"}, fault, 1);
        check({tag, "/to_code"}, faultCode, 2'b11);
      end
      check({tag, "/loadData"}, loadData, m_load);
      @(posedge CLK); #1;
      check({tag, "/done_off"}, done, 0);
      check({tag, "/idle"}, busy, 0);
    end
  endtask

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    int          sel, dly;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    RESET = 1'b1; start = 1'b0; isLoad = 1'b0; isStore = 1'b0; funct3 = 3'd0;
    addr = 32'd0; storeData = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/fault", fault, 0);
    check("rst/code", faultCode, 0);
    check("rst/load", loadData, 0);
    check("rst/rstrb", mem_rstrb, 0);
    check("rst/wmask", mem_wmask, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    run_txn("lw",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    run_txn("lb",  1, 0, 3'b000, 32'h13, 32'h0, 32'h80FF7F01, 0, 0);
    check("lb/value", loadData, 32'hFFFFFF80);
    run_txn("lbu", 1, 0, 3'b100, 32'h13, 32'h0, 32'h80FF7F01, 1, 0);
    check("lbu/value", loadData, 32'h00000080);
    run_txn("lh",  1, 0, 3'b001, 32'h12, 32'h0, 32'h80FF7F01, 2, 0);
    check("lh/value", loadData, 32'hFFFF80FF);
    run_txn("lhu", 1, 0, 3'b101, 32'h12, 32'h0, 32'h80FF7F01, 0, 0);
    check("lhu/value", loadData, 32'h000080FF);
    run_txn("sb",  0, 1, 3'b000, 32'h21, 32'h12345678, 32'h0, 0, 0);
    run_txn("sh",  0, 1, 3'b001, 32'h22, 32'h12345678, 32'h0, 1, 0);
    run_txn("sw",  0, 1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0, 0, 0);
    run_txn("lw_mis", 1, 0, 3'b010, 32'h02, 32'h0, 32'h0, 0, 0);
    check("lw_mis/load_kept", loadData, 32'h000080FF);

    // start with neither op is ignored and the held fault survives it
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("nop/busy", busy, 0);
    check("nop/rstrb", mem_rstrb, 0);
    check("nop/fault_held", fault, 1);
    check("nop/code_held", faultCode, 2'b01);

    run_txn("lw_to", 1, 0, 3'b010, 32'h30, 32'h0, 32'h0, 100, 0);
    run_txn("lw_clr", 1, 0, 3'b010, 32'h08, 32'h0, 32'h13579BDF, 0, 0);
    run_txn("lw_poke", 1, 0, 3'b010, 32'h0C, 32'h0, 32'h2468ACE0, 3, 1);
    run_txn("ill_both", 1, 1, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0);
    run_txn("ill_st", 0, 1, 3'b100, 32'h40, 32'h0, 32'h0, 0, 0);
    run_txn("ill_ld", 1, 0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 19);
      ld  = (sel == 0) || (sel < 11);
      st  = (sel == 0) || (sel >= 11);
      if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      run_txn("rnd", ld, st, f3, $urandom, $urandom, $urandom, dly, 0);
    end

    // reset in WAIT, with a simultaneous start that must be dropped
    start = 1'b1; isLoad = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge CLK); #1;
    start = 1'b0; isLoad = 1'b0;
    @(posedge CLK); #1;
    check("rstw/busy_before", busy, 1);
    RESET = 1'b1; start = 1'b1; isLoad = 1'b1; funct3 = 3'b010; addr = 32'h44;
    @(posedge CLK); #1;
    m_load = 32'd0;
    check("rstw/busy", busy, 0);
    check("rstw/done", done, 0);
    check("rstw/strobes", {mem_rstrb, mem_wmask}, 0);
    check("rstw/fault", fault, 0);
    check("rstw/load", loadData, m_load);
    RESET = 1'b0; start = 1'b0; isLoad = 1'b0;
    @(posedge CLK); #1;
    check("rstw/start_dropped", busy, 0);
    check("rstw/no_strobe", mem_rstrb, 0);
    run_txn("post_rst", 1, 0, 3'b000, 32'h51, 32'h0, 32'h0000F600, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
